minmax_tracker: RTL

- Sequencing stage wrapped around the 16-bit magnitude comparator.
- Accepts a stream of 16-bit unsigned samples and drives each sample, together with a stored reference, onto the comparator's a/b inputs.
- Consumes the comparator's gt/lt/eq flags to maintain the running maximum, the running minimum and a tie count over a frame of FRAME_LEN samples.
- Publishes per-frame results with a one-cycle done strobe.

---
 rtl/minmax_tracker_if.sv | 11 +
 rtl/minmax_tracker.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/minmax_tracker_if.sv
// Sample stream into minmax_tracker.
// valid/ready: a sample moves on any rising edge where sample_valid && sample_ready;
// the master must keep sample_valid and sample_data steady until that edge.
interface minmax_tracker_if;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/minmax_tracker.sv
// Frames a sample stream and uses an external magnitude comparator to track
// per-frame maximum, minimum and ties-with-maximum; results publish with frame_done.
module minmax_tracker #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  minmax_tracker_if.slave      smp,
  output logic [15:0]          cmp_a,
  output logic [15:0]          cmp_b,
  input  logic                 cmp_gt,
  input  logic                 cmp_lt,
  input  logic                 cmp_eq,
  output logic [15:0]          max_out,
  output logic [15:0]          min_out,
  output logic [CNT_W-1:0]     tie_count,
  output logic                 frame_done,
  output logic                 cmp_err,
  output logic [1:0]           state_dbg_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CMP_MAX = 2'd1;
  localparam logic [1:0] S_CMP_MIN = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int               CW      = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]    LAST    = CW'(FRAME_LEN);
  localparam logic [CNT_W-1:0] TIE_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [15:0]      samp_q, samp_d;
  logic [15:0]      max_q, max_d;
  logic [15:0]      min_q, min_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] tie_q, tie_d;
  logic [15:0]      max_out_q, max_out_d;
  logic [15:0]      min_out_q, min_out_d;
  logic [CNT_W-1:0] tie_out_q, tie_out_d;
  logic             err_q, err_d;
  logic             flags_ok;
  logic [CW-1:0]    cnt_inc;

  assign flags_ok = $onehot({cmp_gt, cmp_lt, cmp_eq});
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    max_d     = max_q;
    min_d     = min_q;
    cnt_d     = cnt_q;
    tie_d     = tie_q;
    max_out_d = max_out_q;
    min_out_d = min_out_q;
    tie_out_d = tie_out_q;
    err_d     = err_q;
    cmp_a     = 16'd0;
    cmp_b     = 16'd0;

    case (state_q)
      S_IDLE: begin
        if (smp.sample_valid) begin
          samp_d = smp.sample_data;
          if (cnt_q == '0) begin
            // First sample seeds both extremes without a comparison.
            max_d = smp.sample_data;
            min_d = smp.sample_data;
            cnt_d = CW'(1);
            if (FRAME_LEN == 1) begin
              state_d   = S_DONE;
              max_out_d = smp.sample_data;
              min_out_d = smp.sample_data;
              tie_out_d = tie_q;
            end
          end else begin
            state_d = S_CMP_MAX;
          end
        end
      end
      S_CMP_MAX: begin
        cmp_a   = samp_q;
        cmp_b   = max_q;
        state_d = S_CMP_MIN;
        if (!flags_ok) begin
          err_d = 1'b1;
        end else if (cmp_gt) begin
          max_d = samp_q;
        end else if (cmp_eq && tie_q != TIE_MAX) begin
          tie_d = tie_q + CNT_W'(1);
        end
      end
      S_CMP_MIN: begin
        cmp_a = samp_q;
        cmp_b = min_q;
        cnt_d = cnt_inc;
        if (!flags_ok) begin
          err_d = 1'b1;
        end else if (cmp_lt) begin
          min_d = samp_q;
        end
        if (cnt_inc == LAST) begin
          state_d   = S_DONE;
          max_out_d = max_q;
          min_out_d = min_d;
          tie_out_d = tie_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        samp_d  = 16'd0;
        max_d   = 16'd0;
        min_d   = 16'd0;
        cnt_d   = '0;
        tie_d   = '0;
      end
    endcase

    // Abort drops the frame in flight but leaves the last published results alone.
    if (clear) begin
      state_d   = S_IDLE;
      samp_d    = 16'd0;
      max_d     = 16'd0;
      min_d     = 16'd0;
      cnt_d     = '0;
      tie_d     = '0;
      err_d     = 1'b0;
      max_out_d = max_out_q;
      min_out_d = min_out_q;
      tie_out_d = tie_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      samp_q    <= 16'd0;
      max_q     <= 16'd0;
      min_q     <= 16'd0;
      cnt_q     <= '0;
      tie_q     <= '0;
      max_out_q <= 16'd0;
      min_out_q <= 16'd0;
      tie_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      max_q     <= max_d;
      min_q     <= min_d;
      cnt_q     <= cnt_d;
      tie_q     <= tie_d;
      max_out_q <= max_out_d;
      min_out_q <= min_out_d;
      tie_out_q <= tie_out_d;
      err_q     <= err_d;
    end
  end

  assign smp.sample_ready = (state_q == S_IDLE);
  assign frame_done       = (state_q == S_DONE);
  assign max_out          = max_out_q;
  assign min_out          = min_out_q;
  assign tie_count        = tie_out_q;
  assign cmp_err          = err_q;
  assign state_dbg_o      = state_q;

endmodule
